ioctl_loader: RTL and testbench
===============================

Name: ioctl_loader

Overview:
- Parametrised ioctl download engine for the verilator/MiSTer tops. Replaces the tied-off ioctl_wait with a real handshake.
- Filters downloads by ioctl_index and packs the byte stream into DATA_W-wide words with byte enables.
- Writes each word to a memory port that uses a valid/ready handshake, back-pressuring the HPS via ioctl_wait.
- Sits between the top-level ioctl_* ports and the soc's ROM/RAM.

Parameters:
- DATA_W, 16: memory word width in bits. Legal values: 8, 16, 32, 64.
- ADDR_W, 24: memory word-address width.
- INDEX, 8'h00: ioctl_index value the block accepts.
- INDEX_MASK, 8'hFF: bits of ioctl_index that are compared against INDEX.

Ports:
- clk_sys  in  1  the single clock.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download window.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download target index.
- ioctl_wait  out  1  source must not pulse ioctl_wr while this is high.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  packed word.
- mem_be  out  DATA_W/8  byte enables.
- mem_we  out  1  write request, held until accepted.
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
- load_active  out  1  a matching download is in progress.
- load_done  out  1  one-cycle pulse at the end of a load.
- byte_count  out  25  bytes accepted in the current or last load.

Behaviour:
- Clock and reset: one clock (clk_sys); reset is synchronous and active-high.
- Reset values: every output is 0. Reset drops any pending word, the held byte and the end flag. Reset in mid-operation forces IDLE at the next edge, even if mem_we was high.
- Match: the download matches when (ioctl_index & INDEX_MASK) == (INDEX & INDEX_MASK). Non-matching downloads are ignored entirely: no waits, no writes, counters unchanged.
- Address split: L = log2(DATA_W/8). lane = ioctl_addr[L-1:0]; word address = ioctl_addr[ADDR_W+L-1:L]. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W.
- Packing: little-endian; the byte goes to mem_wdata[8*lane +: 8] and sets be[lane]. A repeated lane overwrites its byte.
- States: IDLE, COLLECT, WRITE, FLUSH, DONE.
- IDLE -> COLLECT on a rising edge of ioctl_download with a matching index. On this transition: load_active=1, byte_count=0, buffer cleared.
- COLLECT, ioctl_wr, same word address as the buffer (or empty buffer):
  - Store the byte and increment byte_count.
  - If the lane is DATA_W/8-1, go to WRITE. mem_we and ioctl_wait rise on the next cycle.
- COLLECT, ioctl_wr, different word address and non-empty buffer:
  - Hold the byte and go to FLUSH; ioctl_wait=1 from the next cycle.
  - FLUSH writes the partial word. After acceptance, the held byte goes into a fresh buffer and the state returns to COLLECT.
- WRITE and FLUSH drive mem_addr, mem_wdata, mem_be and mem_we=1, all stable until mem_ready.
  - If mem_ready is already high, the transfer completes in that first cycle.
  - ioctl_wait=1 for the whole state and falls in the cycle after acceptance.
- COLLECT, falling edge of ioctl_download:
  - Non-empty buffer: FLUSH the partial word, then DONE.
  - Empty buffer: DONE directly.
- Falling edge during WRITE/FLUSH: latched in end_pending and processed after acceptance.
- DONE: load_done=1 for exactly one cycle, load_active=0, then IDLE. byte_count holds its value until the next matching load.
- ioctl_wr pulses that arrive while ioctl_wait=1 are a protocol violation: they are ignored, and an assertion must flag them.
- A zero-length download produces only the load_done pulse, with byte_count=0.
- byte_count saturates at 2^25-1.

Decomposition:
- Package ioctl_pkg holds:
  - the state enum;
  - IOCTL_ADDR_W=25 and IOCTL_DATA_W=8;
  - a lanes(DATA_W) function.
- One sub-module, ioctl_byte_packer: lane insertion, byte-enable accumulation, word-address compare and clear. The FSM and memory handshake stay in ioctl_loader.

Test Plan:
- DATA_W=16, INDEX=0, mem_ready=1:
  - Stimulus: bytes 11,22,33,44 at addresses 0..3.
  - Response: writes (addr0, 2211, be 11) and (addr1, 4433, be 11); one wait cycle per word; load_done once; byte_count=4.
- Odd length, three bytes AA,BB,CC:
  - Response: the final flush writes addr1, wdata[7:0]=CC, be 01 after the falling edge, then load_done.
- Back-pressure: mem_ready low for 5 cycles.
  - Response: mem_we, addr, data and be stay stable; ioctl_wait stays high for 5 cycles and falls one cycle after acceptance.
- Non-sequential addresses 0, then 6:
  - Response: partial write (addr0, be 01) precedes the byte at addr3 lane0; the held byte is not lost.
- ioctl_index=1 with INDEX=0:
  - Response: no mem_we, ioctl_wait stays 0, no load_done, byte_count keeps its previous value.
- Reset asserted while mem_we=1 and mem_ready=0:
  - Response: all outputs are 0 on the next edge; a following download starts cleanly with byte_count=0.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared types and constants for the ioctl download engine.
package ioctl_pkg;
  localparam int IOCTL_ADDR_W = 25;
  localparam int IOCTL_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FLUSH,
    S_DONE
  } state_e;

  function automatic int lanes(input int data_w);
    return data_w / IOCTL_DATA_W;
  endfunction
endpackage

// File: rtl/ioctl_byte_packer.sv
// Assembles ioctl bytes into one little-endian memory word with byte enables.
module ioctl_byte_packer
  import ioctl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    wr,
  input  logic [IOCTL_ADDR_W-1:0] byte_addr,
  input  logic [IOCTL_DATA_W-1:0] byte_din,
  output logic [DATA_W-1:0]       wdata,
  output logic [DATA_W/8-1:0]     be,
  output logic [ADDR_W-1:0]       waddr,
  output logic                    empty,
  output logic                    hit,
  output logic                    last
);
  localparam int NUM_LANES = lanes(DATA_W);
  localparam int L         = $clog2(NUM_LANES);
  localparam int LW        = (L > 0) ? L : 1;

  logic [NUM_LANES-1:0][7:0] data_q, data_d;
  logic [NUM_LANES-1:0]      be_q, be_d, lane_sel;
  logic [ADDR_W-1:0]         waddr_q, waddr_d, in_waddr;
  logic [IOCTL_ADDR_W-1:0]   addr_sh;
  logic [LW-1:0]             lane;
  logic                      unused_addr;

  // Bits above the word address are dropped, so addresses wrap.
  assign addr_sh     = byte_addr >> L;
  assign in_waddr    = addr_sh[ADDR_W-1:0];
  assign lane        = (NUM_LANES > 1) ? byte_addr[LW-1:0] : '0;
  assign unused_addr = ^addr_sh;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_sel[i] = wr && (lane == LW'(i));
  end

  // Clear and write in the same cycle starts a fresh word with this byte.
  always_comb begin
    data_d  = data_q;
    be_d    = be_q;
    waddr_d = waddr_q;
    if (clr) begin
      data_d = '0;
      be_d   = '0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_sel[i]) begin
        data_d[i] = byte_din;
        be_d[i]   = 1'b1;
      end
    end
    if (wr) waddr_d = in_waddr;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_q  <= '0;
      be_q    <= '0;
      waddr_q <= '0;
    end else begin
      data_q  <= data_d;
      be_q    <= be_d;
      waddr_q <= waddr_d;
    end
  end

  assign wdata = data_q;
  assign be    = be_q;
  assign waddr = waddr_q;
  assign empty = ~|be_q;
  assign hit   = empty || (in_waddr == waddr_q);
  assign last  = (lane == LW'(NUM_LANES - 1));
endmodule

// File: rtl/ioctl_loader.sv
// ioctl download engine: filters by index, packs bytes into words and writes
// them through a valid/ready memory port, stalling the HPS with ioctl_wait.
module ioctl_loader
  import ioctl_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter int         ADDR_W     = 24,
  parameter logic [7:0] INDEX      = 8'h00,
  parameter logic [7:0] INDEX_MASK = 8'hFF
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [IOCTL_DATA_W-1:0] ioctl_dout,
  input  logic [7:0]              ioctl_index,
  output logic                    ioctl_wait,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W/8-1:0]     mem_be,
  output logic                    mem_we,
  input  logic                    mem_ready,
  output logic                    load_active,
  output logic                    load_done,
  output logic [IOCTL_ADDR_W-1:0] byte_count
);
  state_e                  state_q, state_d;
  logic                    dl_q, dl_d;
  logic                    end_q, end_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [IOCTL_ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [IOCTL_DATA_W-1:0] hold_data_q, hold_data_d;
  logic [IOCTL_ADDR_W-1:0] count_q, count_d;

  logic                    dl_rise, dl_fall, idx_match, in_xfer;
  logic                    pk_clr, pk_wr, pk_empty, pk_hit, pk_last;
  logic [IOCTL_ADDR_W-1:0] pk_addr;
  logic [IOCTL_DATA_W-1:0] pk_din;

  assign dl_d      = ioctl_download;
  assign dl_rise   = ioctl_download && !dl_q;
  assign dl_fall   = !ioctl_download && dl_q;
  assign idx_match = (ioctl_index & INDEX_MASK) == (INDEX & INDEX_MASK);
  assign in_xfer   = (state_q == S_WRITE) || (state_q == S_FLUSH);

  // While flushing, the packer's next byte is the one parked on the address change.
  assign pk_addr = (state_q == S_FLUSH) ? hold_addr_q : ioctl_addr;
  assign pk_din  = (state_q == S_FLUSH) ? hold_data_q : ioctl_dout;

  ioctl_byte_packer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clr       (pk_clr),
    .wr        (pk_wr),
    .byte_addr (pk_addr),
    .byte_din  (pk_din),
    .wdata     (mem_wdata),
    .be        (mem_be),
    .waddr     (mem_addr),
    .empty     (pk_empty),
    .hit       (pk_hit),
    .last      (pk_last)
  );

  always_comb begin
    state_d     = state_q;
    end_d       = end_q;
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    count_d     = count_q;
    pk_clr      = 1'b0;
    pk_wr       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dl_rise && idx_match) begin
          state_d    = S_COLLECT;
          count_d    = '0;
          end_d      = 1'b0;
          hold_vld_d = 1'b0;
          pk_clr     = 1'b1;
        end
      end
      S_COLLECT: begin
        if (dl_fall) end_d = 1'b1;
        if (ioctl_wr) begin
          count_d = (count_q == '1) ? count_q : count_q + 1'b1;
          if (pk_hit) begin
            pk_wr = 1'b1;
            if (pk_last) state_d = S_WRITE;
          end else begin
            hold_vld_d  = 1'b1;
            hold_addr_d = ioctl_addr;
            hold_data_d = ioctl_dout;
            state_d     = S_FLUSH;
          end
        end else if (dl_fall || end_q) begin
          state_d = pk_empty ? S_DONE : S_FLUSH;
        end
      end
      S_WRITE, S_FLUSH: begin
        if (dl_fall) end_d = 1'b1;
        if (mem_ready) begin
          pk_clr = 1'b1;
          if (hold_vld_q) begin
            // Pending end is picked up again from COLLECT once this byte is written.
            pk_wr      = 1'b1;
            hold_vld_d = 1'b0;
            state_d    = pk_last ? S_WRITE : S_COLLECT;
          end else begin
            state_d = end_d ? S_DONE : S_COLLECT;
          end
        end
      end
      S_DONE: begin
        end_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      end_q       <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      end_q       <= end_d;
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      count_q     <= count_d;
    end
  end

  assign ioctl_wait  = in_xfer;
  assign mem_we      = in_xfer;
  assign load_active = in_xfer || (state_q == S_COLLECT);
  assign load_done   = (state_q == S_DONE);
  assign byte_count  = count_q;

  a_no_wr_during_wait: assert property (@(posedge clk_sys) disable iff (reset)
    !(ioctl_wr && ioctl_wait));
endmodule

// File: tb/tb_ioctl_loader.sv
// Scoreboard bench for ioctl_loader (DATA_W=16, INDEX=0): directed cases plus random loads.
module tb_ioctl_loader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;
  localparam int LANES  = DATA_W / 8;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic [7:0]        ioctl_index = '0;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_be;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic              load_active;
  logic              load_done;
  logic [24:0]       byte_count;

  ioctl_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INDEX(8'h00), .INDEX_MASK(8'hFF)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_ready(mem_ready), .load_active(load_active), .load_done(load_done),
    .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [LANES-1:0]  be;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  n_cmp = 0, n_fail = 0;
  int  wait_cycles = 0, we_cycles = 0, done_cnt = 0;
  bit  ready_mode = 1'b0, ready_fixed = 1'b1, cur_match = 1'b0;

  // Reference word under construction: address, bytes, enables, byte counter.
  logic [ADDR_W-1:0] m_waddr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic [LANES-1:0]  m_be = '0;
  int                m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] bemask(input logic [LANES-1:0] b);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic m_push();
    wr_t w;
    w.a = m_waddr; w.d = m_data; w.be = m_be;
    exp_wr.push_back(w);
    m_be = '0; m_data = '0;
  endtask

  task automatic m_byte(input logic [24:0] a, input logic [7:0] d);
    int                lane;
    logic [ADDR_W-1:0] wa;
    lane = int'(a % 25'(LANES));
    wa   = ADDR_W'(a / 25'(LANES));
    if (m_be != '0 && wa != m_waddr) m_push();
    m_waddr = wa;
    m_data[8*lane +: 8] = d;
    m_be[lane] = 1'b1;
    if (m_cnt < 33554431) m_cnt++;
    if (lane == LANES - 1) m_push();
  endtask

  // mem_ready changes 2 time units after the edge, after the stimulus updates.
  initial forever begin
    @(posedge clk_sys);
    #2;
    mem_ready = ready_mode ? ($urandom_range(0, 1) == 1) : ready_fixed;
  end

  logic        prev_stall = 1'b0;
  logic [63:0] prev_v = '0;
  always @(negedge clk_sys) begin
    wr_t w;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (ioctl_wait) wait_cycles++;
      if (mem_we) we_cycles++;
      if (prev_stall) check("hold_stable", 64'({mem_we, mem_addr, mem_wdata, mem_be}), prev_v);
      if (mem_we && mem_ready) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: addr %0h be %0h, expected no write", mem_addr, mem_be);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(w.a));
          check("wr_be", 64'(mem_be), 64'(w.be));
          check("wr_data", 64'(mem_wdata & bemask(mem_be)), 64'(w.d & bemask(w.be)));
        end
      end
      if (load_done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: byte_count %0d, expected no load_done", byte_count);
        end else begin
          check("done_count", 64'(byte_count), 64'(exp_done.pop_front()));
          check("done_inactive", 64'(load_active), 64'd0);
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_v     = 64'({mem_we, mem_addr, mem_wdata, mem_be});
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_load(input logic [7:0] idx);
    cur_match = (idx == 8'h00);
    if (cur_match) begin m_be = '0; m_data = '0; m_cnt = 0; end
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int k;
    k = 0;
    while (ioctl_wait && k < 500) begin tick(); k++; end
    if (ioctl_wait) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_timeout: ioctl_wait still 1 after %0d cycles, expected 0", k);
    end else begin
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      if (cur_match) m_byte(a, d);
      tick();
      ioctl_wr = 1'b0;
    end
  endtask

  task automatic end_load();
    int start, k;
    start = done_cnt; k = 0;
    ioctl_download = 1'b0;
    if (cur_match) begin
      if (m_be != '0) m_push();
      exp_done.push_back(m_cnt);
      while (done_cnt == start && k < 500) begin tick(); k++; end
      if (done_cnt == start) begin
        n_cmp++; n_fail++;
        $display("FAIL done_timeout: no load_done after %0d cycles, expected one", k);
      end
    end else begin
      repeat (3) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, we0, d0, n;
    logic [24:0] a;
    logic [7:0]  idx;

    repeat (3) tick();
    check("rst_ctrl", 64'({ioctl_wait, mem_we, load_active, load_done, mem_be}), 64'd0);
    check("rst_data", 64'({mem_addr, mem_wdata}), 64'd0);
    check("rst_count", 64'(byte_count), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_ctrl", 64'({ioctl_wait, mem_we, load_active, load_done}), 64'd0);

    // Four sequential bytes, memory always ready.
    ready_fixed = 1'b1;
    w0 = wait_cycles; d0 = done_cnt;
    start_load(8'h00);
    check("active_after_rise", 64'(load_active), 64'd1);
    send_byte(25'd0, 8'h11); send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33); send_byte(25'd3, 8'h44);
    end_load();
    check("t1_wait_cycles", 64'(wait_cycles - w0), 64'd2);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);

    // Odd length: final partial word flushed after the falling edge.
    start_load(8'h00);
    send_byte(25'd0, 8'hAA); send_byte(25'd1, 8'hBB); send_byte(25'd2, 8'hCC);
    end_load();

    // Back-pressure: memory not ready for 5 cycles.
    ready_fixed = 1'b0;
    w0 = wait_cycles;
    start_load(8'h00);
    send_byte(25'd0, 8'h55); send_byte(25'd1, 8'h66);
    repeat (5) @(posedge clk_sys);
    #1;
    check("bp_we_held", 64'({mem_we, ioctl_wait}), 64'd3);
    ready_fixed = 1'b1;
    end_load();
    check("bp_wait_cycles", 64'(wait_cycles - w0), 64'd6);

    // Non-sequential address forces a partial flush, held byte kept.
    start_load(8'h00);
    send_byte(25'd0, 8'h77); send_byte(25'd6, 8'h88);
    end_load();

    // Non-matching index is ignored entirely.
    w0 = wait_cycles; we0 = we_cycles; d0 = done_cnt;
    start_load(8'h01);
    send_byte(25'd0, 8'h12); send_byte(25'd1, 8'h34); send_byte(25'd2, 8'h56);
    end_load();
    check("nm_wait", 64'(wait_cycles - w0), 64'd0);
    check("nm_we", 64'(we_cycles - we0), 64'd0);
    check("nm_done", 64'(done_cnt - d0), 64'd0);
    check("nm_byte_count", 64'(byte_count), 64'd2);

    // Address wrap and zero-length load.
    start_load(8'h00);
    send_byte(25'h1FFFFFF, 8'h9A); send_byte(25'h0000000, 8'hBC);
    end_load();
    start_load(8'h00);
    end_load();

    // Random loads with random back-pressure.
    ready_mode = 1'b1;
    for (int l = 0; l < 30; l++) begin
      idx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      n   = $urandom_range(0, 12);
      a   = 25'($urandom);
      start_load(idx);
      for (int b = 0; b < n; b++) begin
        send_byte(a, 8'($urandom));
        a = ($urandom_range(0, 4) == 0) ? 25'($urandom) : a + 25'd1;
      end
      end_load();
    end
    ready_mode = 1'b0;

    // Reset while a write is stalled.
    ready_fixed = 1'b0;
    tick();
    start_load(8'h00);
    send_byte(25'd20, 8'h01); send_byte(25'd21, 8'h02);
    check("rst_mid_we", 64'(mem_we), 64'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check("rst_mid_ctrl", 64'({ioctl_wait, mem_we, load_active, load_done, mem_be}), 64'd0);
    check("rst_mid_data", 64'({mem_addr, mem_wdata}), 64'd0);
    check("rst_mid_count", 64'(byte_count), 64'd0);
    exp_wr.delete();
    exp_done.delete();
    tick();
    reset = 1'b0;
    ready_fixed = 1'b1;
    tick();
    start_load(8'h00);
    check("restart_count", 64'(byte_count), 64'd0);
    check("restart_active", 64'(load_active), 64'd1);
    send_byte(25'd40, 8'h5A);
    end_load();

    repeat (3) tick();
    check("leftover_writes", 64'(exp_wr.size()), 64'd0);
    check("leftover_dones", 64'(exp_done.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
